// File: rtl/slot_bus_sampler.sv
// Slot bus front end: synchronizes and deglitches the async strobe, captures
// qualified rising-edge events into a FWFT FIFO and flags overflow / stuck strobe.
module slot_bus_sampler #(
  parameter int FILTER_LEN = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 2000
) (
  input  logic       clk_20mhz,
  input  logic       reset,
  input  logic       slot_x,
  input  logic       clk_rw,
  input  logic       ax_d,
  input  logic       r_wx,
  input  logic [7:0] data_in,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_data,
  output logic       ev_ax_d,
  output logic       ev_r_wx,
  output logic [7:0] ev_count,
  output logic       overflow,
  input  logic       ovf_clear,
  output logic       stuck
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [7:0] data;
    logic       ax_d;
    logic       r_wx;
  } ev_t;

  // bus bits: {slot_x, clk_rw, ax_d, r_wx, data_in}
  logic [1:0][11:0] sync;
  logic             s_slot_x, s_clk_rw, s_ax_d, s_r_wx;
  logic [7:0]       s_data;

  always_ff @(posedge clk_20mhz) begin
    if (reset) sync <= '0;
    else       sync <= {sync[0], {slot_x, clk_rw, ax_d, r_wx, data_in}};
  end

  assign {s_slot_x, s_clk_rw, s_ax_d, s_r_wx, s_data} = sync[1];

  // Strobe deglitch: a new level must persist FILTER_LEN cycles.
  logic       filt, filt_q;
  logic [3:0] fcnt;

  always_ff @(posedge clk_20mhz) begin
    if (reset) begin
      filt   <= 1'b1;
      filt_q <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_q <= filt;
      if (s_clk_rw == filt) begin
        fcnt <= '0;
      end else if (fcnt == 4'(FILTER_LEN - 1)) begin
        filt <= ~filt;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 4'd1;
      end
    end
  end

  // Bus fields are captured when the rise first shows up, before qualification.
  ev_t  snap;
  logic snap_slot_x;

  always_ff @(posedge clk_20mhz) begin
    if (reset) begin
      snap        <= '0;
      snap_slot_x <= 1'b1;
    end else if (s_clk_rw && !filt && fcnt == '0) begin
      snap        <= '{data: s_data, ax_d: s_ax_d, r_wx: s_r_wx};
      snap_slot_x <= s_slot_x;
    end
  end

  logic push, pop, full, wr_en, drop;
  logic [AW:0]   cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  ev_t           mem [FIFO_DEPTH];
  ev_t           head;

  assign push     = filt && !filt_q && !snap_slot_x;
  assign full     = (cnt == (AW+1)'(FIFO_DEPTH));
  assign ev_valid = (cnt != '0);
  assign pop      = ev_valid && ev_ready;
  assign wr_en    = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_ff @(posedge clk_20mhz) begin
    if (reset) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= snap;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign ev_data = head.data;
  assign ev_ax_d = head.ax_d;
  assign ev_r_wx = head.r_wx;

  always_ff @(posedge clk_20mhz) begin
    if (reset) begin
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) ev_count <= ev_count + 8'd1;
      // a fresh drop wins over a simultaneous clear
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk_20mhz) begin
    if (reset || !filt)              tcnt <= '0;
    else if (tcnt != TW'(TIMEOUT))   tcnt <= tcnt + TW'(1);
  end

  assign stuck = (tcnt == TW'(TIMEOUT));
endmodule

// File: tb/tb_slot_bus_sampler.sv
// Bench for slot_bus_sampler: vector table of bus cycles, scoreboard queue of
// expected events checked on every pop, plus hand sequences for corner cases.
module tb_slot_bus_sampler;
  localparam int FL = 3;
  localparam int TO = 2000;

  logic       clk = 1'b0;
  logic       reset, slot_x, clk_rw, ax_d, r_wx, ev_ready, ovf_clear;
  logic [7:0] data_in;
  logic       ev_valid, ev_ax_d, ev_r_wx, overflow, stuck;
  logic [7:0] ev_data, ev_count;

  slot_bus_sampler #(.FILTER_LEN(FL), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk_20mhz(clk), .reset(reset), .slot_x(slot_x), .clk_rw(clk_rw),
    .ax_d(ax_d), .r_wx(r_wx), .data_in(data_in), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_data(ev_data), .ev_ax_d(ev_ax_d),
    .ev_r_wx(ev_r_wx), .ev_count(ev_count), .overflow(overflow),
    .ovf_clear(ovf_clear), .stuck(stuck)
  );

  always #25 clk = ~clk;

  typedef struct {
    logic       sx, ad, rw;
    logic [7:0] d;
    int         hi;
    logic       exp_ev;
  } vec_t;

  int         checks = 0, failures = 0;
  logic [9:0] expq [$];
  logic [7:0] exp_cnt = 8'd0;
  vec_t       tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // One clock: compare any pop on the falling edge, then step past the rising edge.
  task automatic step();
    logic [9:0] e;
    @(negedge clk);
    if (!reset && ev_valid && ev_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_pop", {22'd0, ev_data, ev_ax_d, ev_r_wx}, 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        check("pop_entry", {22'd0, ev_data, ev_ax_d, ev_r_wx}, {22'd0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input logic sx, input logic ad, input logic rw,
                           input logic [7:0] d, input int hi, input logic exp_ev);
    slot_x = sx; ax_d = ad; r_wx = rw; data_in = d; clk_rw = 1'b0;
    if (exp_ev) begin
      expq.push_back({d, ad, rw});
      exp_cnt++;
    end
    repeat (6) step();
    clk_rw = 1'b1;
    repeat (hi) step();
    clk_rw = 1'b0;
    repeat (6) step();
  endtask

  task automatic drain();
    ev_ready = 1'b1;
    repeat (10) step();
    check("drain_empty", expq.size(), 0);
    check("drain_valid", ev_valid, 1'b0);
  endtask

  initial begin
    #(50 * 60000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{1'b0, 1'b0, 1'b1, 8'hFF, 4, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h22, 4, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h27, 4, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h55, FL-1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h55, FL, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 8'h20, 4, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h23, 4, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 8'h20, 4, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h23, 4, 1'b1};

    reset = 1'b1; slot_x = 1'b1; clk_rw = 1'b0; ax_d = 1'b0; r_wx = 1'b0;
    data_in = 8'h00; ev_ready = 1'b1; ovf_clear = 1'b0;
    repeat (3) step();
    check("rst_valid", ev_valid, 1'b0);
    check("rst_data", {ev_data, ev_ax_d, ev_r_wx}, 10'd0);
    check("rst_count", ev_count, 8'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_stuck", stuck, 1'b0);
    reset = 1'b0;
    repeat (8) step();

    // rise-to-valid latency on an empty FIFO
    ev_ready = 1'b0; slot_x = 1'b0; data_in = 8'hA5; ax_d = 1'b1; r_wx = 1'b1;
    expq.push_back({8'hA5, 1'b1, 1'b1}); exp_cnt++;
    clk_rw = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (ev_valid) begin n = i; break; end
    end
    check("latency", n, 2 + FL + 1);
    @(posedge clk); #1;
    clk_rw = 1'b0;
    drain();

    for (int i = 0; i < 9; i++) begin
      bus_cycle(tbl[i].sx, tbl[i].ad, tbl[i].rw, tbl[i].d, tbl[i].hi, tbl[i].exp_ev);
      check($sformatf("count_v%0d", i), ev_count, exp_cnt);
      check($sformatf("ovf_v%0d", i), overflow, 1'b0);
    end
    drain();

    // overflow: fifth event dropped while consumer stalls
    ev_ready = 1'b0;
    for (int i = 1; i <= 5; i++) bus_cycle(1'b0, 1'b1, 1'b0, 8'(i), 4, i <= 4);
    check("ovf_set", overflow, 1'b1);
    check("ovf_count", ev_count, exp_cnt);
    ovf_clear = 1'b1; step(); ovf_clear = 1'b0; step();
    check("ovf_clear", overflow, 1'b0);
    drain();

    // full FIFO with pop on the exact push cycle
    ev_ready = 1'b0;
    for (int i = 1; i <= 4; i++) bus_cycle(1'b0, 1'b0, 1'b1, 8'h10 + 8'(i), 4, 1'b1);
    slot_x = 1'b0; data_in = 8'h88; ax_d = 1'b1; r_wx = 1'b1;
    expq.push_back({8'h88, 1'b1, 1'b1}); exp_cnt++;
    repeat (6) step();
    clk_rw = 1'b1;
    repeat (5) step();
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    repeat (2) step();
    clk_rw = 1'b0;
    repeat (6) step();
    check("full_pp_ovf", overflow, 1'b0);
    check("full_pp_count", ev_count, exp_cnt);
    check("full_pp_valid", ev_valid, 1'b1);
    bus_cycle(1'b0, 1'b0, 1'b0, 8'h99, 4, 1'b0);
    check("full_pp_occ", overflow, 1'b1);
    ovf_clear = 1'b1; step(); ovf_clear = 1'b0;
    drain();

    // stuck strobe
    ev_ready = 1'b0; slot_x = 1'b1; clk_rw = 1'b0;
    repeat (6) step();
    clk_rw = 1'b1;
    n = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk); @(negedge clk);
      if (stuck) begin n = i; break; end
    end
    check("stuck_set", n, 2 + FL + TO);
    @(posedge clk); #1;
    clk_rw = 1'b0;
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); @(negedge clk);
      if (!stuck) begin n = i; break; end
    end
    check("stuck_clr", (n >= 1) && (n <= FL + 3), 1'b1);
    @(posedge clk); #1;

    // reset with strobe high: no event until a low is qualified
    ev_ready = 1'b1;
    reset = 1'b1;
    step();
    slot_x = 1'b0; data_in = 8'h77; ax_d = 1'b0; r_wx = 1'b0; clk_rw = 1'b1;
    repeat (4) step();
    check("rst2_data", {ev_data, ev_ax_d, ev_r_wx}, 10'd0);
    check("rst2_count", ev_count, 8'd0);
    reset = 1'b0;
    exp_cnt = 8'd0;
    repeat (30) step();
    check("rst2_noev_valid", ev_valid, 1'b0);
    check("rst2_noev_count", ev_count, 8'd0);
    bus_cycle(1'b0, 1'b1, 1'b1, 8'h78, 4, 1'b1);
    check("rst2_ev_count", ev_count, exp_cnt);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
